scan_index_sequencer: RTL and testbench
=======================================

// Module: scan_index_sequencer
// PURPOSE
//   Sequencer that drives the 4-to-16 one-hot decoder stage. Steps a 4-bit channel index
//   through the enabled channels of a 16-bit mask and holds each channel for a programmable dwell.
//   Inserts a one-cycle break-before-make gap between channels.
//   Outputs feed the decoder's binary input and enable directly (LED/chip-select scan).
// PARAMETERS
//   DWELL_W   8   width of dwell setting and dwell counter
// PORTS
//   clk          in   1        system clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   start        in   1        start a scan (single-cycle pulse; level also accepted)
//   stop         in   1        abort scan, return to IDLE
//   mode_cont    in   1        1 = continuous frames, 0 = single frame
//   chan_mask    in   16       bit i = 1 -> channel i is visited
//   dwell        in   DWELL_W  hold time per channel = dwell+1 cycles
//   binary_out   out  4        channel index to decoder
//   enable_out   out  1        decoder enable
//   busy         out  1        1 in any state other than IDLE
//   frame_done   out  1        one-cycle pulse at end of each frame
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, binary_out=0, enable_out=0, busy=0, frame_done=0.
//   All outputs are registered; counter=0.
//   FSM states are IDLE, DWELL and GAP.
//   IDLE:
//     - start=1, stop=0, chan_mask!=0: latch chan_mask->mask_q, dwell->dwell_q, mode_cont->cont_q.
//       Load idx = lowest set bit of chan_mask and go to DWELL.
//       Next cycle: enable_out=1, binary_out=idx, busy=1.
//     - start=1 with chan_mask==0: no transition; frame_done pulses 1 cycle; enable_out stays 0.
//     - stop has priority over start in the same cycle.
//   DWELL: enable_out=1, counter increments each cycle.
//     When counter==dwell_q: clear counter, go to GAP.
//     Total enable_out high time per channel = dwell_q+1 cycles.
//   GAP (exactly 1 cycle): enable_out=0, binary_out holds the previous index.
//     - Set bit of mask_q above idx: idx <= next higher set bit, go to DWELL.
//     - No such bit (frame end): frame_done=1 this cycle.
//       cont_q=1 -> idx <= lowest set bit, go to DWELL.
//       cont_q=0 -> go to IDLE (busy=0 next cycle).
//   stop=1 in DWELL/GAP: IDLE next cycle with enable_out=0, counter=0, no frame_done.
//     binary_out holds its last value.
//   start in DWELL/GAP is ignored.
//   chan_mask, dwell and mode_cont changes during a scan are ignored until the next start.
//   Single-bit mask: same channel repeats, DWELL+GAP each frame; frame_done every frame.
//   dwell=0: 1 cycle on, 1 cycle gap, so period per channel = 2 cycles.
//   Counter width is DWELL_W; dwell=all-ones gives 2^DWELL_W cycles on, no overflow.
//   enable_out is never high in two different indices without a low cycle in between.
// TESTING
//   1. Reset mid-DWELL (rst_n low 1 cycle) -> all outputs 0 asynchronously.
//      After release: IDLE, busy=0.
//   2. mask=16'h0005, dwell=2, mode_cont=0, start pulse ->
//      - idx 0 enabled 3 cycles, 1 gap, idx 2 enabled 3 cycles, 1 gap.
//      - frame_done on the last gap; busy=0 afterwards.
//   3. mask=16'h8001, dwell=0, mode_cont=1 -> pattern idx 0,gap,idx 15,gap repeats.
//      frame_done every 4 cycles on the gap after idx 15.
//   4. mask=16'h0000 + start -> frame_done 1-cycle pulse, enable_out=0, busy=0.
//   5. Continuous scan of mask=16'hFFFF; assert stop during idx 7 DWELL ->
//      enable_out=0 next cycle, IDLE, no frame_done.
//      Assert start and stop together in IDLE -> stays IDLE.
//   6. Change chan_mask to 16'h0002 mid-frame of mask=16'h0011 ->
//      scan still visits idx 0 then idx 4; new mask takes effect only after the next start.

Source files
------------

// File: rtl/scan_index_sequencer.sv
// Channel scan sequencer for the 4-to-16 one-hot decoder: steps through the enabled
// channels, holds each for dwell+1 cycles and leaves a one-cycle dark gap between channels.
module scan_index_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_cont,
    input  logic [15:0]        chan_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [3:0]         binary_out,
    output logic               enable_out,
    output logic               busy,
    output logic               frame_done
);

    // state  | meaning
    // IDLE   | waiting for start, decoder disabled
    // DWELL  | decoder enabled on idx_q, counting the hold time
    // GAP    | one dark cycle before the next channel (or frame end)
    typedef enum logic [1:0] {S_IDLE, S_DWELL, S_GAP} state_t;

    state_t               state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [15:0]          mask_q, mask_d;
    logic                 cont_q, cont_d;
    logic                 enable_q, enable_d;
    logic                 busy_q, busy_d;
    logic                 fd_q, fd_d;
    logic [4:0]           low_in, low_q, next_q;

    // Result is {found, index}; found=0 means no qualifying bit.
    function automatic logic [4:0] lowest_bit(input logic [15:0] m);
        logic [4:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

    function automatic logic [4:0] next_bit(input logic [15:0] m, input logic [3:0] cur);
        logic [4:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

    assign low_in = lowest_bit(chan_mask);
    assign low_q  = lowest_bit(mask_q);
    assign next_q = next_bit(mask_q, idx_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;
        cont_d  = cont_q;
        fd_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    if (low_in[4]) begin
                        mask_d  = chan_mask;
                        dwell_d = dwell;
                        cont_d  = mode_cont;
                        idx_d   = low_in[3:0];
                        cnt_d   = '0;
                        state_d = S_DWELL;
                    end else begin
                        fd_d = 1'b1;
                    end
                end
            end
            S_DWELL: begin
                if (stop) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == dwell_q) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                    // frame_done is registered, so it is raised on entry to the last gap
                    fd_d    = !next_q[4];
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            S_GAP: begin
                cnt_d = '0;
                if (stop) begin
                    state_d = S_IDLE;
                end else if (next_q[4]) begin
                    idx_d   = next_q[3:0];
                    state_d = S_DWELL;
                end else if (cont_q) begin
                    idx_d   = low_q[3:0];
                    state_d = S_DWELL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        enable_d = (state_d == S_DWELL);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            dwell_q  <= '0;
            mask_q   <= '0;
            cont_q   <= 1'b0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            dwell_q  <= dwell_d;
            mask_q   <= mask_d;
            cont_q   <= cont_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            fd_q     <= fd_d;
        end
    end

    assign binary_out = idx_q;
    assign enable_out = enable_q;
    assign busy       = busy_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_scan_index_sequencer.sv
// Directed bench for scan_index_sequencer: per-cycle vector table plus hand-written
// sequences for reset, stop, maximum dwell and break-before-make.
module tb_scan_index_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mode_cont = 1'b0;
    logic [15:0] chan_mask = '0;
    logic [7:0]  dwell = '0;
    logic [3:0]  binary_out;
    logic        enable_out;
    logic        busy;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    scan_index_sequencer #(.DWELL_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .mode_cont  (mode_cont),
        .chan_mask  (chan_mask),
        .dwell      (dwell),
        .binary_out (binary_out),
        .enable_out (enable_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        st;
        logic        sp;
        logic        md;
        logic [15:0] mk;
        logic [7:0]  dw;
        logic        en;
        logic [3:0]  bin;
        logic        bz;
        logic        fd;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input string nm, input logic st, input logic sp, input logic md,
                                input logic [15:0] mk, input logic [7:0] dw, input logic en,
                                input logic [3:0] bin, input logic bz, input logic fd);
        vec_t v;
        v.name = nm; v.st = st; v.sp = sp; v.md = md; v.mk = mk; v.dw = dw;
        v.en = en; v.bin = bin; v.bz = bz; v.fd = fd;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {25'd0, enable_out, binary_out, busy, frame_done};
    endfunction

    function automatic logic [31:0] pack(input logic en, input logic [3:0] bin, input logic bz,
                                         input logic fd);
        return {25'd0, en, bin, bz, fd};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Break-before-make: enable must drop before the index changes.
    logic       prev_en = 1'b0;
    logic [3:0] prev_bin = '0;
    always @(negedge clk) begin
        if (rst_n && enable_out && prev_en) chk("bbm", {28'd0, binary_out}, {28'd0, prev_bin});
        prev_en  = enable_out;
        prev_bin = binary_out;
    end

    initial begin
        int  hi_cnt;
        int  fd_cnt;
        bit  found;

        // Mask 0x0005, dwell 2, single frame
        add("t2_start", 1, 0, 0, 16'h0005, 8'd2, 1, 4'd0, 1, 0);
        add("t2_d0b",   0, 0, 0, 16'h0005, 8'd2, 1, 4'd0, 1, 0);
        add("t2_d0c",   0, 0, 0, 16'h0005, 8'd2, 1, 4'd0, 1, 0);
        add("t2_gap0",  0, 0, 0, 16'h0005, 8'd2, 0, 4'd0, 1, 0);
        add("t2_d2a",   0, 0, 0, 16'h0005, 8'd2, 1, 4'd2, 1, 0);
        add("t2_d2b",   0, 0, 0, 16'h0005, 8'd2, 1, 4'd2, 1, 0);
        add("t2_d2c",   0, 0, 0, 16'h0005, 8'd2, 1, 4'd2, 1, 0);
        add("t2_gap2",  0, 0, 0, 16'h0005, 8'd2, 0, 4'd2, 1, 1);
        add("t2_idle",  0, 0, 0, 16'h0005, 8'd2, 0, 4'd2, 0, 0);
        // Mask 0x8001, dwell 0, continuous; start during the scan is ignored
        add("t3_d0",    1, 0, 1, 16'h8001, 8'd0, 1, 4'd0,  1, 0);
        add("t3_g0",    0, 0, 1, 16'h8001, 8'd0, 0, 4'd0,  1, 0);
        add("t3_d15",   1, 0, 1, 16'h8001, 8'd0, 1, 4'd15, 1, 0);
        add("t3_g15",   0, 0, 1, 16'h8001, 8'd0, 0, 4'd15, 1, 1);
        add("t3_d0r",   0, 0, 1, 16'h8001, 8'd0, 1, 4'd0,  1, 0);
        add("t3_g0r",   0, 0, 1, 16'h8001, 8'd0, 0, 4'd0,  1, 0);
        add("t3_d15r",  0, 0, 1, 16'h8001, 8'd0, 1, 4'd15, 1, 0);
        add("t3_g15r",  0, 0, 1, 16'h8001, 8'd0, 0, 4'd15, 1, 1);
        add("t3_stop",  0, 1, 1, 16'h8001, 8'd0, 0, 4'd15, 0, 0);
        // Empty mask
        add("t4_zero",  1, 0, 0, 16'h0000, 8'd3, 0, 4'd15, 0, 1);
        add("t4_after", 0, 0, 0, 16'h0000, 8'd3, 0, 4'd15, 0, 0);
        // start and stop together in IDLE
        add("t5_ss",    1, 1, 0, 16'h00FF, 8'd3, 0, 4'd15, 0, 0);
        add("t5_ssb",   0, 0, 0, 16'h00FF, 8'd3, 0, 4'd15, 0, 0);
        // Mask/dwell change mid-frame ignored until next start
        add("t6_d0a",   1, 0, 0, 16'h0011, 8'd1, 1, 4'd0, 1, 0);
        add("t6_d0b",   0, 0, 1, 16'h0002, 8'd0, 1, 4'd0, 1, 0);
        add("t6_g0",    0, 0, 1, 16'h0002, 8'd0, 0, 4'd0, 1, 0);
        add("t6_d4a",   0, 0, 1, 16'h0002, 8'd0, 1, 4'd4, 1, 0);
        add("t6_d4b",   0, 0, 1, 16'h0002, 8'd0, 1, 4'd4, 1, 0);
        add("t6_g4",    0, 0, 1, 16'h0002, 8'd0, 0, 4'd4, 1, 1);
        add("t6_idle",  0, 0, 0, 16'h0002, 8'd0, 0, 4'd4, 0, 0);
        add("t6_new",   1, 0, 0, 16'h0002, 8'd0, 1, 4'd1, 1, 0);
        add("t6_newg",  0, 0, 0, 16'h0002, 8'd0, 0, 4'd1, 1, 1);
        add("t6_newi",  0, 0, 0, 16'h0002, 8'd0, 0, 4'd1, 0, 0);

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", outs(), pack(0, 4'd0, 0, 0));
        rst_n = 1'b1;

        foreach (vq[i]) begin
            start = vq[i].st; stop = vq[i].sp; mode_cont = vq[i].md;
            chan_mask = vq[i].mk; dwell = vq[i].dw;
            step();
            chk(vq[i].name, outs(), pack(vq[i].en, vq[i].bin, vq[i].bz, vq[i].fd));
        end
        start = 1'b0; stop = 1'b0;

        // Stop during idx 7 of a continuous 0xFFFF scan
        chan_mask = 16'hFFFF; dwell = 8'd0; mode_cont = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (enable_out && binary_out == 4'd7) found = 1'b1;
            else step();
        end
        chk("t5_reach7", {31'd0, found}, 32'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t5_stop", outs(), pack(0, 4'd7, 0, 0));
        step();
        chk("t5_stopb", outs(), pack(0, 4'd7, 0, 0));

        // Maximum dwell: 256 enabled cycles, one frame_done
        chan_mask = 16'h0001; dwell = 8'hFF; mode_cont = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        hi_cnt = 0; fd_cnt = 0;
        for (int c = 0; c < 400 && busy; c++) begin
            if (enable_out) hi_cnt++;
            if (frame_done) fd_cnt++;
            step();
        end
        chk("dwell_max_on", hi_cnt, 256);
        chk("dwell_max_fd", fd_cnt, 1);
        chk("dwell_max_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of DWELL
        chan_mask = 16'h0004; dwell = 8'd5; mode_cont = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t1_pre", outs(), pack(1, 4'd2, 1, 0));
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async", outs(), pack(0, 4'd0, 0, 0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("t1_after", outs(), pack(0, 4'd0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
